// File: rtl/etcpu_loader_pkg.sv
// Shared types and helpers for the instruction loader.
package etcpu_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } loader_state_e;

  // Bits of a byte address that advance while walking the instruction memory.
  function automatic logic [31:0] wrap_mask(input int depth);
    return (32'd1 << ($clog2(depth) + 2)) - 32'd1;
  endfunction

endpackage

// File: rtl/etcpu_loader_hold_cnt.sv
// Loadable down-counter with zero flag; times the CPU reset hold after loading.
module etcpu_loader_hold_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/etcpu_inst_loader.sv
// Streams a program into instruction memory and sequences the CPU reset release.
// Optional trailing checksum word enabled by ETCPU_LOADER_CHKSUM_EN.
// state | meaning: IDLE cpu held | LOAD accepting words | HOLD reset countdown | RUN cpu released
module etcpu_inst_loader
  import etcpu_loader_pkg::*;
#(
  parameter int INST_MEM_DEPTH = 256,
  parameter int RST_HOLD       = 4,
  parameter int CNT_W          = $clog2(INST_MEM_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             s_vld,
  input  logic [31:0]      s_dat,
  output logic             s_rdy,
  output logic             inst_mem_wr_wen,
  output logic [31:0]      inst_mem_wr_addr,
  output logic [31:0]      inst_mem_wr_dat,
  output logic             rst_n_cpu,
  output logic             busy,
  output logic             done,
  output logic             len_err,
  output logic             chk_err
);

  localparam int               HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
  localparam logic [31:0]      ADDR_MASK = wrap_mask(INST_MEM_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(INST_MEM_DEPTH);

  loader_state_e    state;
  logic [31:0]      addr;
  logic [31:0]      addr_next;
  logic [CNT_W-1:0] remaining;
  logic             hs;
  logic             too_long;
  logic             csum_word;
  logic             enter_hold;
  logic             hold_zero;

  assign s_rdy     = (state == LOAD);
  assign busy      = (state == LOAD) || (state == HOLD);
  assign hs        = s_vld && s_rdy;
  assign too_long  = (num_words > DEPTH_CNT);
  assign addr_next = (addr & ~ADDR_MASK) | ((addr + 32'(WORD_BYTES)) & ADDR_MASK);

`ifdef ETCPU_LOADER_CHKSUM_EN
  logic [31:0] sum;
  logic        chk_err_q;

  // Once all data words are in, the next accepted word is the expected sum.
  assign csum_word  = (remaining == '0);
  assign enter_hold = hs && csum_word && (s_dat == sum);
  assign chk_err    = chk_err_q;
`else
  assign csum_word  = 1'b0;
  assign enter_hold = (start && !too_long && (num_words == '0) &&
                       ((state == IDLE) || (state == RUN))) ||
                      (hs && (remaining == CNT_W'(1)));
  assign chk_err    = 1'b0;
`endif

  etcpu_loader_hold_cnt #(
    .W(HOLD_W)
  ) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (enter_hold),
    .load_val (HOLD_INIT),
    .dec      (state == HOLD),
    .zero     (hold_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      addr             <= '0;
      remaining        <= '0;
      inst_mem_wr_wen  <= 1'b0;
      inst_mem_wr_addr <= '0;
      inst_mem_wr_dat  <= '0;
      rst_n_cpu        <= 1'b0;
      done             <= 1'b0;
      len_err          <= 1'b0;
`ifdef ETCPU_LOADER_CHKSUM_EN
      sum              <= '0;
      chk_err_q        <= 1'b0;
`endif
    end else begin
      inst_mem_wr_wen <= 1'b0;
      done            <= 1'b0;
      unique case (state)
        IDLE, RUN: begin
          if (start) begin
            if (too_long) begin
              len_err <= 1'b1;
            end else begin
              len_err   <= 1'b0;
              addr      <= base_addr & ~32'd3;
              remaining <= num_words;
              rst_n_cpu <= 1'b0;
              state     <= enter_hold ? HOLD : LOAD;
`ifdef ETCPU_LOADER_CHKSUM_EN
              sum       <= '0;
              chk_err_q <= 1'b0;
`endif
            end
          end
        end
        LOAD: begin
          if (hs) begin
            if (csum_word) begin
              state <= enter_hold ? HOLD : IDLE;
`ifdef ETCPU_LOADER_CHKSUM_EN
              if (!enter_hold) chk_err_q <= 1'b1;
`endif
            end else begin
              inst_mem_wr_wen  <= 1'b1;
              inst_mem_wr_addr <= addr;
              inst_mem_wr_dat  <= s_dat;
              addr             <= addr_next;
              remaining        <= remaining - CNT_W'(1);
`ifdef ETCPU_LOADER_CHKSUM_EN
              sum              <= sum + s_dat;
`endif
              if (enter_hold) state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hold_zero) begin
            state     <= RUN;
            rst_n_cpu <= 1'b1;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
